// File: rtl/clk_meter_pkg.sv
// Shared types and default constants for the clock frequency / duty meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_e;

  localparam int SYS_CLK_HZ      = 27_000_000;
  localparam int GATE_CYCLES_1MS = SYS_CLK_HZ / 1000;
  localparam int TIMEOUT_2MS     = 2 * GATE_CYCLES_1MS;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous signal, plus a delay flop for rising-edge detect.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic s_sync,
  output logic rise
);

  logic s_meta, s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= sig_in;
      s_sync <= s_meta;
      s_prev <= s_sync;
    end
  end

  assign rise = s_sync & ~s_prev;

endmodule

// File: rtl/clk_meter.sv
// Counts rising edges and high samples of sig_in over a fixed gate window,
// re-arming on the next edge so every gate starts edge-aligned.
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int GATE_CYCLES    = GATE_CYCLES_1MS,
  parameter int TIMEOUT_CYCLES = TIMEOUT_2MS,
  parameter int CNT_W          = 16,
  parameter int GATE_W         = $clog2(GATE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              sig_in,
  output logic [CNT_W-1:0]  meas_count,
  output logic [GATE_W-1:0] high_count,
  output logic              meas_ovf,
  output logic              sig_stuck,
  output logic              meas_valid,
  output logic              busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  EDGE_MAX  = {CNT_W{1'b1}};

  logic s_sync, rise;

  sync_edge_det u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .s_sync (s_sync),
    .rise   (rise)
  );

  state_e            state;
  logic [GATE_W-1:0] gate_cnt, high_cnt, high_nxt;
  logic [CNT_W-1:0]  edge_cnt, edge_nxt;
  logic              ovf, ovf_nxt;
  logic [TO_W-1:0]   to_cnt;

  // Next accumulator values include the current cycle, so the last gate cycle counts.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf;
    if (rise) begin
      if (edge_cnt == EDGE_MAX) ovf_nxt  = 1'b1;
      else                      edge_nxt = edge_cnt + 1'b1;
    end
    high_nxt = high_cnt + GATE_W'(s_sync);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      high_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      to_cnt     <= '0;
      meas_count <= '0;
      high_count <= '0;
      meas_ovf   <= 1'b0;
      sig_stuck  <= 1'b0;
      meas_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state  <= ARM;
            busy   <= 1'b1;
            to_cnt <= '0;
          end
        end
        ARM: begin
          if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rise) begin
            // The arming edge itself is not counted.
            state     <= GATE;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            high_cnt  <= '0;
            ovf       <= 1'b0;
            sig_stuck <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            meas_count <= '0;
            high_count <= '0;
            meas_ovf   <= 1'b0;
            sig_stuck  <= 1'b1;
            meas_valid <= 1'b1;
            to_cnt     <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GATE: begin
          if (gate_cnt == GATE_LAST) begin
            meas_count <= edge_nxt;
            high_count <= high_nxt;
            meas_ovf   <= ovf_nxt;
            meas_valid <= 1'b1;
            to_cnt     <= '0;
            state      <= run ? ARM : IDLE;
            busy       <= run;
          end else if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            edge_cnt <= edge_nxt;
            ovf      <= ovf_nxt;
            high_cnt <= high_nxt;
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
// Randomized bench for clk_meter; expected counts come from period/duty arithmetic.
module tb_clk_meter;

  localparam int GATE    = 1000;
  localparam int TIMEOUT = 2000;
  localparam int CW      = 7;
  localparam int GW      = $clog2(GATE + 1);
  localparam int CMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] meas_count;
  logic [GW-1:0] high_count;
  logic          meas_ovf, sig_stuck, meas_valid, busy;

  int checks = 0;
  int errors = 0;

  // Pattern generator: period gen_per clk cycles, high for the first gen_hi of them.
  int gen_per = 10;
  int gen_hi  = 5;
  bit gen_en  = 1'b0;

  clk_meter #(
    .GATE_CYCLES    (GATE),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .sig_in     (sig_in),
    .meas_count (meas_count),
    .high_count (high_count),
    .meas_ovf   (meas_ovf),
    .sig_stuck  (sig_stuck),
    .meas_valid (meas_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always begin : gen
    int p, h;
    if (gen_en) begin
      p = gen_per;
      h = gen_hi;
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        #2 sig_in = (i < h);
      end
    end else begin
      @(negedge clk);
      #2 sig_in = 1'b0;
    end
  end

  task automatic wait_valid(input int bound, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (meas_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no meas_valid within %0d cycles", tag, bound);
    end
  endtask

  task automatic set_pattern(input int p, input int h);
    run = 1'b0;
    @(posedge clk); #1;
    gen_en = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    gen_per = p;
    gen_hi  = h;
    gen_en  = 1'b1;
    run     = 1'b1;
  endtask

  task automatic expect_meas(input string tag, input int p, input int h, input bit stuck);
    int n, hc, ov;
    n  = stuck ? 0 : GATE / p;
    hc = stuck ? 0 : GATE * h / p;
    ov = (n > CMAX) ? 1 : 0;
    if (n > CMAX) n = CMAX;
    checks++;
    if (int'(meas_count) !== n || int'(high_count) !== hc || int'(meas_ovf) !== ov ||
        sig_stuck !== stuck) begin
      errors++;
      $display("FAIL %s: got cnt=%0d high=%0d ovf=%0b stuck=%0b want cnt=%0d high=%0d ovf=%0d stuck=%0b",
               tag, meas_count, high_count, meas_ovf, sig_stuck, n, hc, ov, stuck);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({meas_count, high_count, meas_ovf, sig_stuck, meas_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset: outputs cnt=%0d high=%0d ovf=%0b stuck=%0b vld=%0b busy=%0b want all 0",
               meas_count, high_count, meas_ovf, sig_stuck, meas_valid, busy);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %0b want 0", busy);
    end
  endtask

  task automatic test_ratio;
    bit ok;
    set_pattern(10, 5);
    wait_valid(3000, "ratio_first", ok);
    if (ok) expect_meas("ratio_first", 10, 5, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse: meas_valid got %0b want 0 one cycle later", meas_valid);
    end
    wait_valid(3000, "ratio_repeat", ok);
    if (ok) expect_meas("ratio_repeat", 10, 5, 1'b0);
  endtask

  task automatic test_duty;
    bit ok;
    set_pattern(20, 5);
    wait_valid(3000, "duty_25", ok);
    if (ok) expect_meas("duty_25", 20, 5, 1'b0);
  endtask

  task automatic test_saturation;
    bit ok;
    set_pattern(4, 2);
    wait_valid(3000, "sat_p4", ok);
    if (ok) expect_meas("sat_p4", 4, 2, 1'b0);
    set_pattern(5, 3);
    wait_valid(3000, "sat_p5", ok);
    if (ok) expect_meas("sat_p5", 5, 3, 1'b0);
  endtask

  task automatic test_random;
    int plist[6] = '{8, 10, 20, 25, 40, 50};
    int p, h;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      p = plist[$urandom_range(5, 0)];
      h = $urandom_range(p - 2, 2);
      set_pattern(p, h);
      wait_valid(3000, "rand_first", ok);
      if (ok) expect_meas("rand_first", p, h, 1'b0);
      wait_valid(3000, "rand_b2b", ok);
      if (ok) expect_meas("rand_b2b", p, h, 1'b0);
    end
  endtask

  task automatic test_stuck;
    bit ok, busy_ok;
    int gap;
    run = 1'b0;
    @(posedge clk); #1;
    gen_en = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    run = 1'b1;
    wait_valid(TIMEOUT + 100, "stuck_first", ok);
    if (ok) expect_meas("stuck_first", 1, 0, 1'b1);
    busy_ok = 1'b1;
    gap = 0;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT + 100; i++) begin
      @(posedge clk); #1;
      gap++;
      if (!busy) busy_ok = 1'b0;
      if (meas_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || gap != TIMEOUT) begin
      errors++;
      $display("FAIL stuck_period: got gap %0d (seen=%0b) want %0d", gap, ok, TIMEOUT);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL stuck_busy: busy dropped while armed, want 1 throughout");
    end
    if (ok) expect_meas("stuck_second", 1, 0, 1'b1);
    // Start toggling right after a timeout so the first edge arms well before the next one.
    gen_per = 10;
    gen_hi  = 5;
    gen_en  = 1'b1;
    wait_valid(3000, "stuck_recover", ok);
    if (ok) expect_meas("stuck_recover", 10, 5, 1'b0);
  endtask

  task automatic test_abort;
    bit ok;
    logic [CW-1:0] pc;
    logic [GW-1:0] ph;
    set_pattern(25, 10);
    wait_valid(3000, "abort_prior", ok);
    if (ok) expect_meas("abort_prior", 25, 10, 1'b0);
    pc = meas_count;
    ph = high_count;
    repeat (400) @(posedge clk);
    #1;
    run = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %0b want 0 one edge after run drop", busy);
    end
    ok = 1'b0;
    repeat (1500) begin
      @(posedge clk); #1;
      if (meas_valid) ok = 1'b1;
    end
    checks++;
    if (ok || meas_count !== pc || high_count !== ph || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold: vld_seen=%0b cnt=%0d high=%0d busy=%0b want 0 %0d %0d 0",
               ok, meas_count, high_count, busy, pc, ph);
    end
    run = 1'b1;
    wait_valid(3000, "abort_rerun", ok);
    if (ok) expect_meas("abort_rerun", 25, 10, 1'b0);
  endtask

  task automatic test_reset_mid;
    bit ok;
    set_pattern(20, 5);
    wait_valid(3000, "rstmid_prior", ok);
    repeat (600) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({meas_count, high_count, meas_ovf, sig_stuck, meas_valid, busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: cnt=%0d high=%0d ovf=%0b stuck=%0b vld=%0b busy=%0b want all 0",
               meas_count, high_count, meas_ovf, sig_stuck, meas_valid, busy);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_valid(3000, "rstmid_full", ok);
    if (ok) expect_meas("rstmid_full", 20, 5, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ratio();
    test_duty();
    test_saturation();
    test_random();
    test_stuck();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
